// File: rtl/spi_pkg.sv
// Shared definitions for the SPI subordinate burst bridge.
//   - spi_op_e    : two-bit operation code carried at the head of every frame
//   - spi_state_e : frame sequencer states
//   - DEF_ADDR_W / DEF_DATA_W : default field widths
//   - max_w()     : helper that sizes a shifter able to hold either field
package spi_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_WR  = 2'b01,
      OP_RD  = 2'b10,
      OP_RSV = 2'b11
   } spi_op_e;

   typedef enum logic [2:0] {
      IDLE,
      OP,
      ADDR,
      WDATA,
      RTURN,
      RDATA,
      SKIP
   } spi_state_e;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parametrised MSB-first shift register with parallel load.
//   sclk     : clock, all state on posedge
//   rst      : synchronous active-high clear
//   load     : parallel load of load_val (wins over shift)
//   load_val : parallel load value
//   shift    : shift one place towards the MSB, sin enters at bit 0
//   sin      : serial input
//   q        : register contents; q[W-1] is the serial output
module spi_shift_reg #(
   parameter int W = 8
) (
   input  logic         sclk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift,
   input  logic         sin,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;

   always_ff @(posedge sclk) begin
      if (rst) begin
         q_reg <= '0;
      end else if (load) begin
         q_reg <= load_val;
      end else if (shift) begin
         q_reg <= {q_reg[W-2:0], sin};
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/spi_sub_burst.sv
// SPI subordinate that turns host frames (op, address, data; MSB first) into
// single-cycle register-bus strobes, with a read path on miso, burst address
// auto-increment and a frame error pulse when cs_n rises mid-word.
//   sclk      : sole clock, posedge
//   rst       : synchronous active-high reset
//   cs_n      : chip select, active low; high means idle / abort
//   mosi      : host serial data, sampled on posedge
//   miso      : registered serial read data, 0 outside RDATA
//   r_en      : one-cycle read strobe (addr valid, data_i expected same cycle)
//   w_en      : one-cycle write strobe (addr, data_o valid)
//   addr      : word address for the current strobe
//   data_o    : write data
//   data_i    : read data from the register file
//   frame_err : one-cycle pulse when a word is cut short by cs_n
module spi_sub_burst
   import spi_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter bit BURST_EN = 1'b1
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              r_en,
   output logic              w_en,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              frame_err
);

   localparam int RX_W  = max_w(ADDR_W, DATA_W);
   localparam int CNT_W = $clog2(RX_W);
   localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   spi_state_e        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              op_rd_reg, op_rd_next;
   logic [ADDR_W-1:0] word_addr_reg, word_addr_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_W-1:0] data_o_reg, data_o_next;
   logic              r_en_reg, r_en_next;
   logic              w_en_reg, w_en_next;
   logic              miso_reg, miso_next;
   logic              frame_err_reg, frame_err_next;

   logic [RX_W-1:0]   rx_q;
   logic [RX_W-1:0]   rx_sample;
   logic [DATA_W-1:0] tx_q;
   logic              rx_shift, tx_load, tx_shift;
   logic              addr_last, data_last;
   spi_op_e           op_sample;
   logic              unused_msbs;

   // Receive shifter: every mosi bit up to the end of a write word.
   spi_shift_reg #(.W(RX_W)) u_rx (
      .sclk     (sclk),
      .rst      (rst),
      .load     (1'b0),
      .load_val ('0),
      .shift    (rx_shift),
      .sin      (mosi),
      .q        (rx_q)
   );

   // Transmit shifter: loaded from data_i at the end of the turnaround cycle.
   spi_shift_reg #(.W(DATA_W)) u_tx (
      .sclk     (sclk),
      .rst      (rst),
      .load     (tx_load),
      .load_val (data_i),
      .shift    (tx_shift),
      .sin      (1'b0),
      .q        (tx_q)
   );

   assign rx_shift  = !cs_n && (state_reg inside {IDLE, OP, ADDR, WDATA});
   assign tx_load   = !cs_n && (state_reg == RTURN);
   assign tx_shift  = !cs_n && (state_reg == RDATA);

   // Field values including the bit being sampled on this edge, so a field
   // can be consumed on the same edge that completes it.
   assign rx_sample = {rx_q[RX_W-2:0], mosi};
   assign op_sample = spi_op_e'(rx_sample[1:0]);
   assign addr_last = (cnt_reg == ADDR_LAST);
   assign data_last = (cnt_reg == DATA_LAST);

   // miso is driven from miso_reg, so the shifter MSBs are never read out.
   assign unused_msbs = rx_q[RX_W-1] ^ tx_q[DATA_W-1];

   // ---------------- state register ----------------
   always_ff @(posedge sclk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (cs_n) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            IDLE: state_next = OP;
            OP: begin
               cnt_next   = '0;
               state_next = (op_sample == OP_WR || op_sample == OP_RD) ? ADDR : SKIP;
            end
            ADDR: begin
               if (addr_last) begin
                  cnt_next   = '0;
                  state_next = op_rd_reg ? RTURN : WDATA;
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end
            WDATA: begin
               if (data_last) begin
                  cnt_next   = '0;
                  state_next = BURST_EN ? WDATA : SKIP;
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end
            RTURN: begin
               cnt_next   = '0;
               state_next = RDATA;
            end
            RDATA: begin
               // The edge on which the host takes the last bit already opens
               // the turnaround for the following word.
               if (data_last) begin
                  cnt_next   = '0;
                  state_next = BURST_EN ? RTURN : SKIP;
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end
            default: state_next = state_reg;
         endcase
      end
   end

   // ---------------- output / datapath next values ----------------
   always_comb begin
      r_en_next      = 1'b0;
      w_en_next      = 1'b0;
      miso_next      = 1'b0;
      frame_err_next = 1'b0;
      addr_next      = addr_reg;
      data_o_next    = data_o_reg;
      word_addr_next = word_addr_reg;
      op_rd_next     = op_rd_reg;
      if (cs_n) begin
         case (state_reg)
            OP, ADDR, RDATA: frame_err_next = 1'b1;
            // WDATA with no bits shifted is a clean word boundary in a burst.
            WDATA:           frame_err_next = (cnt_reg != '0);
            default:         frame_err_next = 1'b0;
         endcase
      end else begin
         case (state_reg)
            OP: op_rd_next = (op_sample == OP_RD);
            ADDR: begin
               if (addr_last) begin
                  if (op_rd_reg) begin
                     r_en_next      = 1'b1;
                     addr_next      = rx_sample[ADDR_W-1:0];
                     word_addr_next = rx_sample[ADDR_W-1:0] + ADDR_ONE;
                  end else begin
                     word_addr_next = rx_sample[ADDR_W-1:0];
                  end
               end
            end
            WDATA: begin
               if (data_last) begin
                  w_en_next      = 1'b1;
                  addr_next      = word_addr_reg;
                  data_o_next    = rx_sample[DATA_W-1:0];
                  word_addr_next = word_addr_reg + ADDR_ONE;
               end
            end
            RTURN: miso_next = data_i[DATA_W-1];
            RDATA: begin
               if (data_last) begin
                  if (BURST_EN) begin
                     r_en_next      = 1'b1;
                     addr_next      = word_addr_reg;
                     word_addr_next = word_addr_reg + ADDR_ONE;
                  end
               end else begin
                  // Next bit down; tx_q shifts on this same edge.
                  miso_next = tx_q[DATA_W-2];
               end
            end
            default: miso_next = 1'b0;
         endcase
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         r_en_reg      <= 1'b0;
         w_en_reg      <= 1'b0;
         miso_reg      <= 1'b0;
         frame_err_reg <= 1'b0;
         addr_reg      <= '0;
         data_o_reg    <= '0;
         word_addr_reg <= '0;
         op_rd_reg     <= 1'b0;
      end else begin
         r_en_reg      <= r_en_next;
         w_en_reg      <= w_en_next;
         miso_reg      <= miso_next;
         frame_err_reg <= frame_err_next;
         addr_reg      <= addr_next;
         data_o_reg    <= data_o_next;
         word_addr_reg <= word_addr_next;
         op_rd_reg     <= op_rd_next;
      end
   end

   assign r_en      = r_en_reg;
   assign w_en      = w_en_reg;
   assign miso      = miso_reg;
   assign frame_err = frame_err_reg;
   assign addr      = addr_reg;
   assign data_o    = data_o_reg;

endmodule

// File: tb/tb_spi_sub_burst.sv
module tb_spi_sub_burst;

   logic        sclk = 1'b0;
   logic        rst  = 1'b1;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;

   logic        miso, r_en, w_en, frame_err;
   logic [9:0]  addr;
   logic [31:0] data_o, data_i;
   logic        miso0, r_en0, w_en0, frame_err0;
   logic [9:0]  addr0;
   logic [31:0] data_o0, data_i0;

   int n_cmp = 0;
   int n_bad = 0;

   bit          tx_bits[$];
   logic        miso_s[$];
   int          wen_k[$];
   logic [9:0]  wen_a[$];
   logic [31:0] wen_d[$];
   int          ren_k[$];
   logic [9:0]  ren_a[$];
   int          ferr_n, ren0_n, wen0_n, both_n;

   always #5 sclk = ~sclk;

   // Register-file model: answers reads from the presented address.
   function automatic logic [31:0] rd_val(input logic [9:0] a);
      if (a == 10'h2A4) return 32'hDEADBEEF;
      return {22'h2B3C5, a};
   endfunction

   assign data_i  = rd_val(addr);
   assign data_i0 = rd_val(addr0);

   spi_sub_burst #(.ADDR_W(10), .DATA_W(32), .BURST_EN(1'b1)) dut (
      .sclk(sclk), .rst(rst), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .r_en(r_en), .w_en(w_en), .addr(addr), .data_o(data_o),
      .data_i(data_i), .frame_err(frame_err)
   );

   spi_sub_burst #(.ADDR_W(10), .DATA_W(32), .BURST_EN(1'b0)) dut0 (
      .sclk(sclk), .rst(rst), .cs_n(cs_n), .mosi(mosi), .miso(miso0),
      .r_en(r_en0), .w_en(w_en0), .addr(addr0), .data_o(data_o0),
      .data_i(data_i0), .frame_err(frame_err0)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One sclk cycle: at the negedge, log what the DUTs present (this is what
   // the host sees at the coming posedge fk), then drive the inputs for it.
   task automatic step(input logic c, input logic b, input logic r, input int fk);
      @(negedge sclk);
      miso_s.push_back(miso);
      if (w_en) begin wen_k.push_back(fk); wen_a.push_back(addr); wen_d.push_back(data_o); end
      if (r_en) begin ren_k.push_back(fk); ren_a.push_back(addr); end
      if (w_en && r_en) both_n++;
      if (frame_err) ferr_n++;
      if (r_en0) ren0_n++;
      if (w_en0) wen0_n++;
      cs_n = c;
      mosi = b;
      rst  = r;
   endtask

   task automatic clear_log();
      miso_s.delete(); wen_k.delete(); wen_a.delete(); wen_d.delete();
      ren_k.delete(); ren_a.delete();
      ferr_n = 0; ren0_n = 0; wen0_n = 0;
   endtask

   task automatic push_bits(input logic [31:0] v, input int w);
      for (int i = w - 1; i >= 0; i--) tx_bits.push_back(v[i]);
   endtask

   task automatic run(input int idle);
      int n;
      n = tx_bits.size();
      clear_log();
      for (int k = 0; k < n; k++) step(1'b0, tx_bits[k], 1'b0, k);
      for (int k = n; k < n + idle; k++) step(1'b1, 1'b0, 1'b0, k);
      tx_bits.delete();
   endtask

   function automatic logic [31:0] miso_word(input int lo);
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 32; i++) w = {w[30:0], miso_s[lo + i]};
      return w;
   endfunction

   initial begin
      both_n = 0;
      clear_log();

      // ---- reset state ----
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 0);
      @(negedge sclk);
      check("rst_w_en", w_en, 0);
      check("rst_r_en", r_en, 0);
      check("rst_miso", miso, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_addr", addr, 0);
      check("rst_data_o", data_o, 0);
      rst = 1'b0;
      step(1'b1, 1'b0, 1'b0, 0);
      $display("txn reset done");

      // ---- single write 0x100 <- 0x12345678 ----
      push_bits(2'b01, 2); push_bits(10'h100, 10); push_bits(32'h12345678, 32);
      run(4);
      check("wr_count", wen_k.size(), 1);
      check("wr_cycle", wen_k[0], 44);
      check("wr_addr", wen_a[0], 10'h100);
      check("wr_data", wen_d[0], 32'h12345678);
      check("wr_no_ren", ren_k.size(), 0);
      check("wr_no_ferr", ferr_n, 0);
      check("wr_nob_count", wen0_n, 1);
      $display("txn write addr=100 data=12345678");

      // ---- single read 0x2A4 ----
      push_bits(2'b10, 2); push_bits(10'h2A4, 10);
      for (int i = 0; i < 33; i++) tx_bits.push_back(1'b0);
      run(3);
      check("rd_ren_cycle", ren_k[0], 12);
      check("rd_addr", ren_a[0], 10'h2A4);
      // burst on: the last-bit edge already starts the next word's turnaround
      check("rd_ren_count", ren_k.size(), 2);
      check("rd_turn_miso", miso_s[12], 0);
      check("rd_miso_word", miso_word(13), 32'hDEADBEEF);
      check("rd_miso_after", miso_s[45], 0);
      check("rd_no_wen", wen_k.size(), 0);
      check("rd_no_ferr", ferr_n, 0);
      check("rd_nob_ren", ren0_n, 1);
      $display("txn read addr=2a4 data=deadbeef");

      // ---- burst write at 0x3FE, three words ----
      push_bits(2'b01, 2); push_bits(10'h3FE, 10);
      push_bits(32'h0000000A, 32); push_bits(32'h0000000B, 32); push_bits(32'h0000000C, 32);
      run(4);
      check("bw_count", wen_k.size(), 3);
      check("bw_k0", wen_k[0], 44);
      check("bw_k1", wen_k[1], 76);
      check("bw_k2", wen_k[2], 108);
      check("bw_a0", wen_a[0], 10'h3FE);
      check("bw_a1", wen_a[1], 10'h3FF);
      check("bw_a2", wen_a[2], 10'h000);
      check("bw_d0", wen_d[0], 32'hA);
      check("bw_d1", wen_d[1], 32'hB);
      check("bw_d2", wen_d[2], 32'hC);
      check("bw_no_ferr", ferr_n, 0);
      check("bw_nob_count", wen0_n, 1);
      $display("txn burst write addr=3fe words=3");

      // ---- burst read, two words from 0x010 ----
      push_bits(2'b10, 2); push_bits(10'h010, 10);
      for (int i = 0; i < 66; i++) tx_bits.push_back(1'b0);
      run(3);
      check("br_k0", ren_k[0], 12);
      check("br_k1", ren_k[1], 45);
      check("br_a0", ren_a[0], 10'h010);
      check("br_a1", ren_a[1], 10'h011);
      check("br_count", ren_k.size(), 3);
      check("br_turn_miso", miso_s[45], 0);
      check("br_word0", miso_word(13), 32'h0ACF1410);
      check("br_word1", miso_word(46), 32'h0ACF1411);
      check("br_no_ferr", ferr_n, 0);
      check("br_nob_ren", ren0_n, 1);
      $display("txn burst read addr=010 words=2");

      // ---- write aborted at k=20, then a full write ----
      push_bits(2'b01, 2); push_bits(10'h155, 10); push_bits(8'hFF, 8);
      run(3);
      check("ab_ferr", ferr_n, 1);
      check("ab_no_wen", wen_k.size(), 0);
      $display("txn aborted write at k=20");
      push_bits(2'b01, 2); push_bits(10'h0AB, 10); push_bits(32'hCAFEF00D, 32);
      run(3);
      check("ab2_count", wen_k.size(), 1);
      check("ab2_addr", wen_a[0], 10'h0AB);
      check("ab2_data", wen_d[0], 32'hCAFEF00D);
      check("ab2_no_ferr", ferr_n, 0);
      $display("txn write addr=0ab data=cafef00d");

      // ---- nop frame ----
      push_bits(2'b00, 2); push_bits(10'h3FF, 10); push_bits(32'hFFFFFFFF, 32);
      run(3);
      check("nop_no_wen", wen_k.size(), 0);
      check("nop_no_ren", ren_k.size(), 0);
      check("nop_no_ferr", ferr_n, 0);
      $display("txn nop frame");

      // ---- reset at k=30 of a write ----
      push_bits(2'b01, 2); push_bits(10'h200, 10); push_bits(32'h55AA55AA, 32);
      clear_log();
      for (int k = 0; k < 30; k++) step(1'b0, tx_bits[k], 1'b0, k);
      step(1'b0, tx_bits[30], 1'b1, 30);
      tx_bits.delete();
      @(negedge sclk);
      check("mr_w_en", w_en, 0);
      check("mr_r_en", r_en, 0);
      check("mr_miso", miso, 0);
      check("mr_frame_err", frame_err, 0);
      check("mr_addr", addr, 0);
      check("mr_data_o", data_o, 0);
      rst  = 1'b0;
      cs_n = 1'b1;
      for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0, k);
      check("mr_no_wen", wen_k.size(), 0);
      check("mr_no_ferr", ferr_n, 0);
      check("never_both", both_n, 0);
      $display("txn reset mid-write");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_sub_burst.md
Name: spi_sub_burst

Overview:
Parametrised next-generation SPI subordinate bridging a serial host frame (op, address, data; MSB first) onto a single-cycle register-bus strobe interface.
- Generalises the fixed 2/10/32-bit frame to ADDR_W/DATA_W.
- Adds a full read path on miso, burst auto-increment and an abort/error indication.
- Sits between the chip-level SPI pins and the register file; runs entirely in the sclk domain.

Parameters:
ADDR_W, 10, address field width and addr port width
DATA_W, 32, data field width and data_o/data_i width
BURST_EN, 1, 1 = additional words in the same cs_n-low window go to addr+1; 0 = one word per frame

Ports:
sclk  input  1  sole clock, all logic on posedge
rst  input  1  synchronous, active-high reset
cs_n  input  1  chip select, active low; high = idle/abort
mosi  input  1  serial data from host, sampled on posedge sclk
miso  output  1  serial read data, registered, changes only on posedge
r_en  output  1  one-cycle read strobe
w_en  output  1  one-cycle write strobe
addr  output  ADDR_W  word address, valid while r_en/w_en high
data_o  output  DATA_W  write data, valid while w_en high
data_i  input  DATA_W  read data from register file, valid in the same cycle as r_en
frame_err  output  1  one-cycle pulse: cs_n rose mid-word

Behaviour:
- Reset (rst high at posedge): state IDLE; all counters cleared.
  - r_en, w_en, miso and frame_err reset to 0; addr and data_o reset to 0.
  - Reset overrides cs_n. A frame in progress is discarded with no strobe and no frame_err.
- Cycle k: the k-th posedge with cs_n low, counting from 0.
- Op codes: 01 write, 10 read; 00 nop and 11 reserved both go to SKIP.
- States:
  - IDLE: cs_n low samples op[1] -> OP.
  - OP: samples op[0], then decodes -> ADDR or SKIP.
  - ADDR: shifts ADDR_W bits; the last bit is sampled at k=ADDR_W+1. Then write -> WDATA; read -> RTURN, with r_en registered high for the next cycle.
  - WDATA: shifts DATA_W bits. After the last sample, w_en is high for exactly one cycle, with data_o/addr held from a capture register. The shift register keeps accepting the next burst word while w_en is high.
  - RTURN (one turnaround cycle, r_en high): data_i is captured into the read shifter at the posedge ending this cycle; miso then presents bit DATA_W-1 -> RDATA.
  - RDATA: miso shifts one bit per posedge. The host samples bits at k=ADDR_W+3 .. ADDR_W+2+DATA_W.
  - SKIP: ignores mosi, holds miso at 0, stays until cs_n high.
- Frame lengths at defaults:
  - Write: 44 cycles, w_en in the cycle after k=43.
  - Read: 45 cycles including turnaround.
- Burst, with BURST_EN=1 and cs_n still low after a word:
  - addr increments by 1, modulo 2^ADDR_W (0x3FF -> 0x000).
  - Write: next DATA_W bits -> WDATA; w_en every DATA_W cycles.
  - Read: the cycle after the last miso bit is an RTURN cycle for the next address (r_en high), giving DATA_W+1 cycles per word.
  - BURST_EN=0: go to SKIP after the first word.
- cs_n high at a posedge:
  - In any state, return to IDLE and drive miso to 0.
  - In OP, ADDR or WDATA, or with a partial RDATA word, also pulse frame_err for one cycle. Partial words never produce w_en.
  - A strobe already registered for the current cycle still completes.
- miso is 0 whenever not in RDATA. r_en and w_en are never simultaneously high.

Decomposition:
- Shared package spi_pkg:
  - op enum (OP_NOP, OP_WR, OP_RD, OP_RSV).
  - state enum (IDLE, OP, ADDR, WDATA, RTURN, RDATA, SKIP).
  - Default width constants.
- One natural sub-module, spi_shift_reg: a parametrised MSB-first shift register with load, shift and serial in/out. It is instantiated twice: rx (mosi) and tx (miso).

Test Plan:
- Write op=01, addr=0x100, data=0x12345678 -> exactly one w_en, at the cycle after k=43, with addr=0x100 and data_o=0x12345678; r_en stays 0.
- Read op=10, addr=0x2A4, data_i=0xDEADBEEF during r_en -> r_en one cycle after k=11, addr=0x2A4; miso bits at k=13..44 reassemble to 0xDEADBEEF.
- Burst write at 0x3FE with words 0xA, 0xB, 0xC, cs_n held low -> three w_en pulses 32 cycles apart, addr 0x3FE, 0x3FF, 0x000.
- Burst read with 2 words from 0x010 -> r_en at 0x010 and 0x011, 33 cycles apart; both words correct on miso. Repeat with BURST_EN=0 -> a single r_en only.
- Write frame with cs_n raised at k=20 -> no w_en, one frame_err pulse, state IDLE; the next full write frame succeeds.
- Op=00 frame of 44 bits -> no strobes and no frame_err. Separately, rst asserted at k=30 of a write -> no w_en, all outputs 0 the next cycle.
